// File: rtl/logic16_arbiter.sv
// rtl/logic16_arbiter.sv - round-robin shared 16-bit NOT/AND/OR/XOR unit with registered result
// Requesters compete for one gate datapath; the result stage is a single back-pressurable register.
module logic16_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_out,
  output logic [IDW-1:0]          rsp_id,
  output logic [15:0]             txn_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   rsp_out_q, rsp_out_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [15:0]        txn_count_q, txn_count_d;

  logic               found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_idx;
  logic [NREQ-1:0]    grant;
  logic               can_accept;
  logic               hs;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b, result;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found    = 1'b1;
        grant_id = scan_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[grant_id] = 1'b1;
  end

  // rst_n gates ready so nothing handshakes while the block is held in reset.
  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign hs         = found & can_accept & rst_n;
  assign req_ready  = grant & {NREQ{can_accept & rst_n}};

  assign sel_op = req_op[2*int'(grant_id) +: 2];
  assign sel_a  = req_a[WIDTH*int'(grant_id) +: WIDTH];
  assign sel_b  = req_b[WIDTH*int'(grant_id) +: WIDTH];

  always_comb begin
    result = '0;
    case (sel_op)
      2'b00:   result = ~sel_a;
      2'b01:   result = sel_a & sel_b;
      2'b10:   result = sel_a | sel_b;
      default: result = sel_a ^ sel_b;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_out_d    = rsp_out_q;
    rsp_id_d     = rsp_id_q;
    txn_count_d  = txn_count_q;
    if (hs) begin
      state_d      = FULL;
      last_grant_d = grant_id;
      rsp_out_d    = result;
      rsp_id_d     = grant_id;
      txn_count_d  = txn_count_q + 16'd1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= IDW'(NREQ - 1);
      rsp_out_q    <= '0;
      rsp_id_q     <= '0;
      txn_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_out_q    <= rsp_out_d;
      rsp_id_q     <= rsp_id_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_out   = rsp_out_q;
  assign rsp_id    = rsp_id_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_logic16_arbiter.sv
// tb/tb_logic16_arbiter.sv - directed-vector bench for logic16_arbiter
module tb_logic16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic [1:0]  rsp_id;
  logic [15:0] txn_count;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_res [4];

  logic16_arbiter #(.NREQ(4), .WIDTH(16), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[2*i +: 2]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;

    // 1: reset with all valids high
    repeat (3) @(negedge clk);
    check_vec("rst_ready", 32'(req_ready), 32'h0);
    check_vec("rst_valid", 32'(rsp_valid), 32'h0);
    check_vec("rst_out",   32'(rsp_out),   32'h0);
    check_vec("rst_id",    32'(rsp_id),    32'h0);
    check_vec("rst_cnt",   32'(txn_count), 32'h0);

    // 2: single NOT request from requester 0
    rst_n     = 1'b1;
    set_req(0, 2'b00, 16'h1234, 16'h5555);
    req_valid = 4'b0001;
    #1 check_vec("t2_ready", 32'(req_ready), 32'h1);
    @(posedge clk); @(negedge clk);
    req_valid = 4'b0000;
    check_vec("t2_valid", 32'(rsp_valid), 32'h1);
    check_vec("t2_out",   32'(rsp_out),   32'hEDCB);
    check_vec("t2_id",    32'(rsp_id),    32'h0);
    check_vec("t2_cnt",   32'(txn_count), 32'h1);
    @(posedge clk); @(negedge clk);
    check_vec("t2_drain", 32'(rsp_valid), 32'h0);
    check_vec("t2_hold",  32'(rsp_out),   32'hEDCB);

    // 3: all four valid, round-robin from 0
    do_reset();
    set_req(0, 2'b01, 16'hFFFF, 16'h00FF); exp_res[0] = 16'h00FF;
    set_req(1, 2'b10, 16'hF000, 16'h000F); exp_res[1] = 16'hF00F;
    set_req(2, 2'b11, 16'hAAAA, 16'h0F0F); exp_res[2] = 16'hA5A5;
    set_req(3, 2'b00, 16'h0000, 16'h1234); exp_res[3] = 16'hFFFF;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check_vec($sformatf("t3_ready%0d", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
      @(posedge clk); @(negedge clk);
      check_vec($sformatf("t3_id%0d", i),  32'(rsp_id),  32'(i % 4));
      check_vec($sformatf("t3_out%0d", i), 32'(rsp_out), 32'(exp_res[i % 4]));
    end
    check_vec("t3_cnt", 32'(txn_count), 32'd6);
    req_valid = 4'b0000;
    @(posedge clk); @(negedge clk);

    // 4: backpressure on requester 1's AND result, then fairness
    set_req(1, 2'b01, 16'h3CC3, 16'hFFFF);
    req_valid = 4'b0010;
    #1 check_vec("t4_ready", 32'(req_ready), 32'h2);
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    check_vec("t4_valid", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec($sformatf("t4_bp_ready%0d", i), 32'(req_ready), 32'h0);
      check_vec($sformatf("t4_bp_out%0d", i),   32'(rsp_out),   32'h3CC3);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check_vec("t4_next_ready", 32'(req_ready), 32'h4);
    @(posedge clk); @(negedge clk);
    req_valid = 4'b0000;
    check_vec("t4_next_id",  32'(rsp_id),    32'h2);
    check_vec("t4_next_out", 32'(rsp_out),   32'hA5A5);
    check_vec("t4_cnt",      32'(txn_count), 32'd8);

    // 5: txn_count wrap
    do_reset();
    set_req(0, 2'b00, 16'h1234, 16'h0000);
    req_valid = 4'b0001;
    repeat (16'hFFFE) @(posedge clk);
    @(negedge clk);
    check_vec("t5_fffe", 32'(txn_count), 32'hFFFE);
    @(posedge clk); @(negedge clk);
    check_vec("t5_ffff", 32'(txn_count), 32'hFFFF);
    @(posedge clk); @(negedge clk);
    check_vec("t5_wrap", 32'(txn_count), 32'h0000);

    // 6: asynchronous reset while FULL
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk); @(negedge clk);
    check_vec("t6_full", 32'(rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_vec("t6_valid", 32'(rsp_valid), 32'h0);
    check_vec("t6_out",   32'(rsp_out),   32'h0);
    check_vec("t6_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1 check_vec("t6_first_ready", 32'(req_ready), 32'h1);
    @(posedge clk); @(negedge clk);
    check_vec("t6_first_id",  32'(rsp_id),  32'h0);
    check_vec("t6_first_out", 32'(rsp_out), 32'hEDCB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
